// File: rtl/axi4_slave_mem.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : axi4_slave_mem                                                |
// | Brief    : AXI4 slave word memory with FIXED/INCR/WRAP bursts, SLVERR    |
// |            reporting and a doorbell word mirrored onto IRQ.              |
// |            Optional macro AXI4_SLAVE_MEM_STALL_EN adds LFSR back-pressure.|
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module axi4_slave_mem #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int WID_WIDTH  = 4,
  parameter int RID_WIDTH  = 4,
  parameter int IRQ_WIDTH  = 1,
  parameter int MEM_AW     = 10,
  parameter int STRB_WIDTH = DATA_WIDTH / 8
) (
  input  logic                  ACLK,
  input  logic                  ARESETn,
  input  logic                  AWVALID,
  output logic                  AWREADY,
  input  logic [ADDR_WIDTH-1:0] AWADDR,
  input  logic [7:0]            AWLEN,
  input  logic [1:0]            AWBURST,
  input  logic [WID_WIDTH-1:0]  AWID,
  input  logic                  WVALID,
  output logic                  WREADY,
  input  logic [DATA_WIDTH-1:0] WDATA,
  input  logic [STRB_WIDTH-1:0] WSTRB,
  output logic                  BVALID,
  input  logic                  BREADY,
  output logic [1:0]            BRESP,
  output logic [WID_WIDTH-1:0]  BID,
  input  logic                  ARVALID,
  output logic                  ARREADY,
  input  logic [ADDR_WIDTH-1:0] ARADDR,
  input  logic [7:0]            ARLEN,
  input  logic [1:0]            ARBURST,
  input  logic [RID_WIDTH-1:0]  ARID,
  output logic                  RVALID,
  input  logic                  RREADY,
  output logic [DATA_WIDTH-1:0] RDATA,
  output logic [1:0]            RRESP,
  output logic [RID_WIDTH-1:0]  RID,
  output logic [IRQ_WIDTH-1:0]  IRQ
);

  localparam int LSB = $clog2(STRB_WIDTH);
  localparam int HI  = LSB + MEM_AW;
  localparam int DEPTH = 1 << MEM_AW;

  typedef enum logic [1:0] {W_IDLE = 2'd0, W_DATA = 2'd1, W_RESP = 2'd2} w_state_t;
  typedef enum logic [1:0] {R_IDLE = 2'd0, R_LOAD = 2'd1, R_DATA = 2'd2} r_state_t;

  function automatic logic [MEM_AW-1:0] next_idx(input logic [MEM_AW-1:0] idx,
                                                 input logic [1:0] burst,
                                                 input logic [7:0] len);
    logic [MEM_AW-1:0] m;
    logic [MEM_AW-1:0] inc;
    m   = MEM_AW'(len);
    inc = idx + MEM_AW'(1);
    case (burst)
      2'b01:   next_idx = inc;
      2'b10:   next_idx = (idx & ~m) | (inc & m);
      default: next_idx = idx;
    endcase
  endfunction

  function automatic logic req_err(input logic [1:0] burst, input logic [7:0] len,
                                   input logic oor);
    logic wrap_bad;
    wrap_bad = (burst == 2'b10) && !(len inside {8'd1, 8'd3, 8'd7, 8'd15});
    req_err  = (burst == 2'b11) || wrap_bad || oor;
  endfunction

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic stall;
`ifdef AXI4_SLAVE_MEM_STALL_EN
  logic [7:0] lfsr_q, lfsr_d;
  always_comb lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
  always_ff @(posedge ACLK) begin
    if (!ARESETn) lfsr_q <= 8'hA5;
    else          lfsr_q <= lfsr_d;
  end
  assign stall = lfsr_q[0];
`else
  assign stall = 1'b0;
`endif

  // ---------------- write path ----------------
  w_state_t              w_state_q, w_state_d;
  logic [MEM_AW-1:0]     w_idx_q, w_idx_d;
  logic [7:0]            w_len_q, w_len_d, w_cnt_q, w_cnt_d;
  logic [1:0]            w_burst_q, w_burst_d;
  logic [WID_WIDTH-1:0]  w_id_q, w_id_d;
  logic                  w_err_q, w_err_d;
  logic                  awready_q, awready_d, wready_q, wready_d, bvalid_q, bvalid_d;
  logic [IRQ_WIDTH-1:0]  irq_q, irq_d;
  logic [DATA_WIDTH-1:0] w_mask;
  logic                  w_beat, w_ready_out;

  assign w_ready_out = wready_q & ~stall;

  always_comb begin
    w_mask = '0;
    for (int b = 0; b < STRB_WIDTH; b++) w_mask[b*8 +: 8] = {8{WSTRB[b]}};
  end

  always_comb begin
    w_state_d = w_state_q;
    w_idx_d   = w_idx_q;
    w_len_d   = w_len_q;
    w_cnt_d   = w_cnt_q;
    w_burst_d = w_burst_q;
    w_id_d    = w_id_q;
    w_err_d   = w_err_q;
    irq_d     = irq_q;
    w_beat    = 1'b0;
    case (w_state_q)
      W_IDLE: if (AWVALID && awready_q) begin
        w_idx_d   = AWADDR[HI-1:LSB];
        w_len_d   = AWLEN;
        w_burst_d = AWBURST;
        w_id_d    = AWID;
        w_err_d   = req_err(AWBURST, AWLEN, |(AWADDR >> HI));
        w_cnt_d   = 8'd0;
        w_state_d = W_DATA;
      end
      W_DATA: if (WVALID && w_ready_out) begin
        w_beat  = 1'b1;
        w_idx_d = next_idx(w_idx_q, w_burst_q, w_len_q);
        w_cnt_d = w_cnt_q + 8'd1;
        if (w_cnt_q == w_len_q) w_state_d = W_RESP;
        // The top word doubles as the doorbell; dropped beats never ring it.
        if (!w_err_q && w_idx_q == MEM_AW'(DEPTH - 1))
          irq_d = (irq_q & ~w_mask[IRQ_WIDTH-1:0]) | (WDATA[IRQ_WIDTH-1:0] & w_mask[IRQ_WIDTH-1:0]);
      end
      W_RESP: if (BREADY && bvalid_q) w_state_d = W_IDLE;
      default: w_state_d = W_IDLE;
    endcase
    awready_d = (w_state_d == W_IDLE);
    wready_d  = (w_state_d == W_DATA);
    bvalid_d  = (w_state_d == W_RESP);
  end

  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      w_state_q <= W_IDLE;
      w_idx_q   <= '0;
      w_len_q   <= '0;
      w_cnt_q   <= '0;
      w_burst_q <= '0;
      w_id_q    <= '0;
      w_err_q   <= 1'b0;
      irq_q     <= '0;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
    end else begin
      w_state_q <= w_state_d;
      w_idx_q   <= w_idx_d;
      w_len_q   <= w_len_d;
      w_cnt_q   <= w_cnt_d;
      w_burst_q <= w_burst_d;
      w_id_q    <= w_id_d;
      w_err_q   <= w_err_d;
      irq_q     <= irq_d;
      awready_q <= awready_d;
      wready_q  <= wready_d;
      bvalid_q  <= bvalid_d;
    end
  end

  always_ff @(posedge ACLK) begin
    if (ARESETn && w_beat && !w_err_q) begin
      for (int b = 0; b < STRB_WIDTH; b++)
        if (WSTRB[b]) mem[w_idx_q][b*8 +: 8] <= WDATA[b*8 +: 8];
    end
  end

  // ---------------- read path ----------------
  r_state_t              r_state_q, r_state_d;
  logic [MEM_AW-1:0]     r_idx_q, r_idx_d;
  logic [7:0]            r_len_q, r_len_d, r_cnt_q, r_cnt_d;
  logic [1:0]            r_burst_q, r_burst_d;
  logic [RID_WIDTH-1:0]  r_id_q, r_id_d;
  logic                  r_err_q, r_err_d;
  logic                  arready_q, arready_d, rvalid_q, rvalid_d;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic                  r_load;

  always_comb begin
    r_state_d = r_state_q;
    r_idx_d   = r_idx_q;
    r_len_d   = r_len_q;
    r_cnt_d   = r_cnt_q;
    r_burst_d = r_burst_q;
    r_id_d    = r_id_q;
    r_err_d   = r_err_q;
    r_load    = 1'b0;
    case (r_state_q)
      R_IDLE: if (ARVALID && arready_q) begin
        r_idx_d   = ARADDR[HI-1:LSB];
        r_len_d   = ARLEN;
        r_burst_d = ARBURST;
        r_id_d    = ARID;
        r_err_d   = req_err(ARBURST, ARLEN, |(ARADDR >> HI));
        r_cnt_d   = 8'd0;
        r_state_d = R_LOAD;
      end
      R_LOAD: if (!stall) begin
        r_load    = 1'b1;
        r_state_d = R_DATA;
      end
      R_DATA: if (RREADY && rvalid_q) begin
        if (r_cnt_q == r_len_q) begin
          r_state_d = R_IDLE;
        end else begin
          r_idx_d   = next_idx(r_idx_q, r_burst_q, r_len_q);
          r_cnt_d   = r_cnt_q + 8'd1;
          r_state_d = R_LOAD;
        end
      end
      default: r_state_d = R_IDLE;
    endcase
    arready_d = (r_state_d == R_IDLE);
    rvalid_d  = (r_state_d == R_DATA);
  end

  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      r_state_q <= R_IDLE;
      r_idx_q   <= '0;
      r_len_q   <= '0;
      r_cnt_q   <= '0;
      r_burst_q <= '0;
      r_id_q    <= '0;
      r_err_q   <= 1'b0;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
    end else begin
      r_state_q <= r_state_d;
      r_idx_q   <= r_idx_d;
      r_len_q   <= r_len_d;
      r_cnt_q   <= r_cnt_d;
      r_burst_q <= r_burst_d;
      r_id_q    <= r_id_d;
      r_err_q   <= r_err_d;
      arready_q <= arready_d;
      rvalid_q  <= rvalid_d;
    end
  end

  // Reads the array before any same-edge write lands, so a colliding read sees old data.
  always_ff @(posedge ACLK) begin
    if (!ARESETn)    rdata_q <= '0;
    else if (r_load) rdata_q <= r_err_q ? '0 : mem[r_idx_q];
  end

  assign AWREADY = awready_q;
  assign WREADY  = w_ready_out;
  assign BVALID  = bvalid_q;
  assign BRESP   = bvalid_q ? {w_err_q, 1'b0} : 2'b00;
  assign BID     = bvalid_q ? w_id_q : '0;
  assign ARREADY = arready_q;
  assign RVALID  = rvalid_q;
  assign RDATA   = rdata_q;
  assign RRESP   = rvalid_q ? {r_err_q, 1'b0} : 2'b00;
  assign RID     = rvalid_q ? r_id_q : '0;
  assign IRQ     = irq_q;

endmodule
`default_nettype wire

// File: tb/tb_axi4_slave_mem.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_axi4_slave_mem                                             |
// | Brief    : Directed self-checking bench for axi4_slave_mem.              |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module tb_axi4_slave_mem;

  localparam int TMO = 50;
  localparam int NV  = 17;

  logic        ACLK = 1'b0;
  logic        ARESETn;
  logic        AWVALID, AWREADY;
  logic [31:0] AWADDR;
  logic [7:0]  AWLEN;
  logic [1:0]  AWBURST;
  logic [3:0]  AWID;
  logic        WVALID, WREADY;
  logic [31:0] WDATA;
  logic [3:0]  WSTRB;
  logic        BVALID, BREADY;
  logic [1:0]  BRESP;
  logic [3:0]  BID;
  logic        ARVALID, ARREADY;
  logic [31:0] ARADDR;
  logic [7:0]  ARLEN;
  logic [1:0]  ARBURST;
  logic [3:0]  ARID;
  logic        RVALID, RREADY;
  logic [31:0] RDATA;
  logic [1:0]  RRESP;
  logic [3:0]  RID;
  logic [0:0]  IRQ;

  int checks = 0;
  int errors = 0;

  axi4_slave_mem dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .AWVALID(AWVALID), .AWREADY(AWREADY), .AWADDR(AWADDR), .AWLEN(AWLEN),
    .AWBURST(AWBURST), .AWID(AWID),
    .WVALID(WVALID), .WREADY(WREADY), .WDATA(WDATA), .WSTRB(WSTRB),
    .BVALID(BVALID), .BREADY(BREADY), .BRESP(BRESP), .BID(BID),
    .ARVALID(ARVALID), .ARREADY(ARREADY), .ARADDR(ARADDR), .ARLEN(ARLEN),
    .ARBURST(ARBURST), .ARID(ARID),
    .RVALID(RVALID), .RREADY(RREADY), .RDATA(RDATA), .RRESP(RRESP), .RID(RID),
    .IRQ(IRQ)
  );

  always #5 ACLK = ~ACLK;

  typedef struct {
    bit               is_write;
    logic [31:0]      addr;
    logic [7:0]       len;
    logic [1:0]       burst;
    logic [3:0]       id;
    logic [3:0]       strb;
    logic [3:0][31:0] d;      // write data, or expected read data
    logic [1:0]       resp;
  } vec_t;

  vec_t vec [NV];

  function automatic vec_t mk(input bit w, input logic [31:0] a, input logic [7:0] l,
                              input logic [1:0] bu, input logic [3:0] id, input logic [3:0] s,
                              input logic [31:0] x0, input logic [31:0] x1,
                              input logic [31:0] x2, input logic [31:0] x3,
                              input logic [1:0] rs);
    vec_t v;
    v.is_write = w; v.addr = a; v.len = l; v.burst = bu; v.id = id; v.strb = s;
    v.d[0] = x0; v.d[1] = x1; v.d[2] = x2; v.d[3] = x3; v.resp = rs;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %h required %h", nm, act, exp);
    end
  endtask

  task automatic timeout(input string nm);
    checks++;
    errors++;
    $display("FAIL %s: timed out after %0d cycles", nm, TMO);
  endtask

  // All tasks start and end on a falling edge.
  task automatic aw_send(input logic [31:0] a, input logic [7:0] l, input logic [1:0] bu,
                         input logic [3:0] id);
    int n = 0;
    AWADDR = a; AWLEN = l; AWBURST = bu; AWID = id; AWVALID = 1'b1;
    while (!AWREADY && n < TMO) begin @(negedge ACLK); n++; end
    if (n == TMO) timeout("aw_handshake");
    @(negedge ACLK);
    AWVALID = 1'b0;
  endtask

  task automatic w_beat(input logic [31:0] dat, input logic [3:0] s);
    int n = 0;
    WDATA = dat; WSTRB = s; WVALID = 1'b1;
    while (!WREADY && n < TMO) begin @(negedge ACLK); n++; end
    if (n == TMO) timeout("w_handshake");
    @(negedge ACLK);
    WVALID = 1'b0;
  endtask

  task automatic b_recv(output logic [1:0] rs, output logic [3:0] id);
    int n = 0;
    BREADY = 1'b1;
    while (!BVALID && n < TMO) begin @(negedge ACLK); n++; end
    if (n == TMO) timeout("b_handshake");
    rs = BRESP; id = BID;
    @(negedge ACLK);
    BREADY = 1'b0;
  endtask

  task automatic ar_send(input logic [31:0] a, input logic [7:0] l, input logic [1:0] bu,
                         input logic [3:0] id);
    int n = 0;
    ARADDR = a; ARLEN = l; ARBURST = bu; ARID = id; ARVALID = 1'b1;
    while (!ARREADY && n < TMO) begin @(negedge ACLK); n++; end
    if (n == TMO) timeout("ar_handshake");
    @(negedge ACLK);
    ARVALID = 1'b0;
  endtask

  task automatic r_recv(output logic [31:0] dat, output logic [1:0] rs, output logic [3:0] id);
    int n = 0;
    RREADY = 1'b1;
    while (!RVALID && n < TMO) begin @(negedge ACLK); n++; end
    if (n == TMO) timeout("r_handshake");
    dat = RDATA; rs = RRESP; id = RID;
    @(negedge ACLK);
    RREADY = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_awready"}, 32'(AWREADY), 32'd0);
    chk({tag, "_wready"},  32'(WREADY),  32'd0);
    chk({tag, "_bvalid"},  32'(BVALID),  32'd0);
    chk({tag, "_bresp"},   32'(BRESP),   32'd0);
    chk({tag, "_bid"},     32'(BID),     32'd0);
    chk({tag, "_arready"}, 32'(ARREADY), 32'd0);
    chk({tag, "_rvalid"},  32'(RVALID),  32'd0);
    chk({tag, "_rdata"},   RDATA,        32'd0);
    chk({tag, "_rresp"},   32'(RRESP),   32'd0);
    chk({tag, "_rid"},     32'(RID),     32'd0);
    chk({tag, "_irq"},     32'(IRQ),     32'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0]  rs;
    logic [3:0]  id;
    logic [31:0] dat;

    vec[0]  = mk(1, 32'h100,  8'd3, 2'b01, 4'h5, 4'hF, 32'h11, 32'h22, 32'h33, 32'h44, 2'b00);
    vec[1]  = mk(0, 32'h100,  8'd3, 2'b01, 4'h6, 4'hF, 32'h11, 32'h22, 32'h33, 32'h44, 2'b00);
    vec[2]  = mk(1, 32'h100,  8'd3, 2'b01, 4'h1, 4'hF, 32'h40, 32'h41, 32'h42, 32'h43, 2'b00);
    vec[3]  = mk(0, 32'h10C,  8'd3, 2'b10, 4'h2, 4'hF, 32'h43, 32'h40, 32'h41, 32'h42, 2'b00);
    vec[4]  = mk(1, 32'h200,  8'd0, 2'b01, 4'h3, 4'hF, 32'h12345678, 0, 0, 0, 2'b00);
    vec[5]  = mk(1, 32'h200,  8'd0, 2'b01, 4'h4, 4'h2, 32'hFFFFFFFF, 0, 0, 0, 2'b00);
    vec[6]  = mk(0, 32'h200,  8'd0, 2'b01, 4'h7, 4'hF, 32'h1234FF78, 0, 0, 0, 2'b00);
    vec[7]  = mk(0, 32'h1000, 8'd1, 2'b01, 4'h8, 4'hF, 32'h0, 32'h0, 0, 0, 2'b10);
    vec[8]  = mk(1, 32'h200,  8'd0, 2'b11, 4'h9, 4'hF, 32'hDEADBEEF, 0, 0, 0, 2'b10);
    vec[9]  = mk(0, 32'h200,  8'd0, 2'b01, 4'hA, 4'hF, 32'h1234FF78, 0, 0, 0, 2'b00);
    vec[10] = mk(1, 32'h300,  8'd2, 2'b00, 4'hB, 4'hF, 32'hA, 32'hB, 32'hC, 0, 2'b00);
    vec[11] = mk(0, 32'h300,  8'd1, 2'b00, 4'hC, 4'hF, 32'hC, 32'hC, 0, 0, 2'b00);
    vec[12] = mk(0, 32'h300,  8'd2, 2'b10, 4'hD, 4'hF, 32'h0, 32'h0, 32'h0, 0, 2'b10);
    vec[13] = mk(1, 32'h204,  8'd1, 2'b10, 4'hE, 4'hF, 32'hA1, 32'hA2, 0, 0, 2'b00);
    vec[14] = mk(0, 32'h200,  8'd1, 2'b01, 4'hF, 4'hF, 32'hA2, 32'hA1, 0, 0, 2'b00);
    vec[15] = mk(1, 32'h1100, 8'd0, 2'b01, 4'h1, 4'hF, 32'h55, 0, 0, 0, 2'b10);
    vec[16] = mk(0, 32'h100,  8'd0, 2'b01, 4'h2, 4'hF, 32'h40, 0, 0, 0, 2'b00);

    ARESETn = 1'b0;
    AWVALID = 0; AWADDR = 0; AWLEN = 0; AWBURST = 0; AWID = 0;
    WVALID = 0; WDATA = 0; WSTRB = 0; BREADY = 0;
    ARVALID = 0; ARADDR = 0; ARLEN = 0; ARBURST = 0; ARID = 0; RREADY = 0;

    repeat (3) @(negedge ACLK);
    chk_all_zero("reset");
    ARESETn = 1'b1;
    @(negedge ACLK);
    chk("post_reset_awready", 32'(AWREADY), 32'd1);
    chk("post_reset_arready", 32'(ARREADY), 32'd1);
    chk("post_reset_wready",  32'(WREADY),  32'd0);

    for (int i = 0; i < NV; i++) begin
      if (vec[i].is_write) begin
        aw_send(vec[i].addr, vec[i].len, vec[i].burst, vec[i].id);
        for (int b = 0; b <= int'(vec[i].len); b++) w_beat(vec[i].d[b], vec[i].strb);
        b_recv(rs, id);
        chk($sformatf("v%0d_bresp", i), 32'(rs), 32'(vec[i].resp));
        chk($sformatf("v%0d_bid", i),   32'(id), 32'(vec[i].id));
      end else begin
        ar_send(vec[i].addr, vec[i].len, vec[i].burst, vec[i].id);
        for (int b = 0; b <= int'(vec[i].len); b++) begin
          r_recv(dat, rs, id);
          chk($sformatf("v%0d_b%0d_rdata", i, b), dat, vec[i].d[b]);
          chk($sformatf("v%0d_b%0d_rresp", i, b), 32'(rs), 32'(vec[i].resp));
          chk($sformatf("v%0d_b%0d_rid", i, b),   32'(id), 32'(vec[i].id));
        end
      end
    end

    // Read latency and RVALID/RDATA hold under back-pressure.
    ARADDR = 32'h100; ARLEN = 8'd0; ARBURST = 2'b01; ARID = 4'h3; ARVALID = 1'b1;
    chk("lat_arready", 32'(ARREADY), 32'd1);
    @(negedge ACLK);
    ARVALID = 1'b0;
    chk("lat_rvalid_c1", 32'(RVALID), 32'd0);
    chk("lat_arready_c1", 32'(ARREADY), 32'd0);
    @(negedge ACLK);
    chk("lat_rvalid_c2", 32'(RVALID), 32'd1);
    chk("lat_rdata_c2", RDATA, 32'h40);
    @(negedge ACLK);
    chk("hold_rvalid", 32'(RVALID), 32'd1);
    chk("hold_rdata", RDATA, 32'h40);
    chk("hold_rid", 32'(RID), 32'h3);
    RREADY = 1'b1;
    @(negedge ACLK);
    RREADY = 1'b0;
    chk("lat_rvalid_done", 32'(RVALID), 32'd0);
    chk("lat_arready_back", 32'(ARREADY), 32'd1);

    // Doorbell rises the edge after the W beat.
    aw_send(32'hFFC, 8'd0, 2'b01, 4'h1);
    WDATA = 32'h1; WSTRB = 4'hF; WVALID = 1'b1;
    chk("irq_wready", 32'(WREADY), 32'd1);
    chk("irq_before_beat", 32'(IRQ), 32'd0);
    @(negedge ACLK);
    WVALID = 1'b0;
    chk("irq_after_beat", 32'(IRQ), 32'd1);
    b_recv(rs, id);
    chk("irq_bresp", 32'(rs), 32'd0);

    aw_send(32'hFFC, 8'd0, 2'b01, 4'h2);
    w_beat(32'h0, 4'hF);
    chk("irq_cleared", 32'(IRQ), 32'd0);
    b_recv(rs, id);

    aw_send(32'hFFC, 8'd0, 2'b01, 4'h3);
    w_beat(32'h1, 4'hF);
    b_recv(rs, id);
    aw_send(32'hFFC, 8'd0, 2'b01, 4'h4);
    w_beat(32'h0, 4'hE);
    chk("irq_strobe_masked", 32'(IRQ), 32'd1);
    b_recv(rs, id);

    // Reset in the middle of a 4-beat write.
    aw_send(32'h100, 8'd3, 2'b01, 4'h2);
    w_beat(32'h77, 4'hF);
    WDATA = 32'h88; WSTRB = 4'hF; WVALID = 1'b1;
    ARESETn = 1'b0;
    @(negedge ACLK);
    chk_all_zero("midrst");
    WVALID = 1'b0;
    ARESETn = 1'b1;
    @(negedge ACLK);
    chk("midrst_awready", 32'(AWREADY), 32'd1);
    for (int c = 0; c < 3; c++) begin
      chk($sformatf("midrst_no_b_%0d", c), 32'(BVALID), 32'd0);
      @(negedge ACLK);
    end
    ar_send(32'h100, 8'd1, 2'b01, 4'h5);
    r_recv(dat, rs, id);
    chk("midrst_word0", dat, 32'h77);
    r_recv(dat, rs, id);
    chk("midrst_word1", dat, 32'h41);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/axi4_slave_mem.md
Name: axi4_slave_mem

Overview:
- AXI4 slave memory model that sits directly downstream of the simbus AXI4 master slot. It consumes the slot's address, write-data and read channels and returns B and R responses and IRQ.
- Used as the default DUT/target behind a slot for bring-up and regression of remote masters.
- Word-wide accesses only; FIXED, INCR and WRAP bursts; write and read paths run independently.
- A doorbell register drives the IRQ lines.

Parameters:
- data_width, 32: data bus width; one of 32/64/128.
- addr_width, 32: AWADDR/ARADDR width.
- wid_width, 4: AWID/BID width.
- rid_width, 4: ARID/RID width.
- irq_width, 1: IRQ width; must be <= data_width.
- mem_aw, 10: log2 of memory depth in words.
- strb_width, data_width/8: WSTRB width.

Ports:
- ACLK  in  1  clock; all logic on rising edge.
- ARESETn  in  1  synchronous, active-low reset.
- AWVALID  in  1  write address valid.
- AWREADY  out  1  write address ready.
- AWADDR  in  addr_width  byte address of first beat.
- AWLEN  in  8  beats minus 1.
- AWBURST  in  2  00 FIXED, 01 INCR, 10 WRAP, 11 reserved.
- AWID  in  wid_width  write transaction id.
- WVALID  in  1  write data valid.
- WREADY  out  1  write data ready.
- WDATA  in  data_width  write data.
- WSTRB  in  strb_width  byte enables.
- BVALID  out  1  write response valid.
- BREADY  in  1  write response ready.
- BRESP  out  2  00 OKAY, 10 SLVERR.
- BID  out  wid_width  echo of AWID.
- ARVALID  in  1  read address valid.
- ARREADY  out  1  read address ready.
- ARADDR  in  addr_width  byte address of first beat.
- ARLEN  in  8  beats minus 1.
- ARBURST  in  2  burst type, as AWBURST.
- ARID  in  rid_width  read transaction id.
- RVALID  out  1  read data valid.
- RREADY  in  1  read data ready.
- RDATA  out  data_width  read data.
- RRESP  out  2  00 OKAY, 10 SLVERR.
- RID  out  rid_width  echo of ARID.
- IRQ  out  irq_width  doorbell register value.

Behaviour:
- Reset (ARESETn=0 at edge): every output is 0, both FSMs go to IDLE, the beat counters clear and the doorbell clears. Memory array is not reset.
- Address decode:
  - Word index = addr[lsb+mem_aw-1:lsb], where lsb = log2(data_width/8). Low lsb bits are ignored.
  - Any nonzero addr bit at or above lsb+mem_aw makes that beat out of range.
- Burst address update, per accepted beat:
  - FIXED: index unchanged.
  - INCR: index+1, wrapping modulo depth.
  - WRAP: index = (index & ~len) | ((index+1) & len). Legal only for len in {1,3,7,15}.
- A transaction is SLVERR when any of these holds:
  - reserved burst type;
  - illegal WRAP length;
  - any beat out of range.
- SLVERR effects: writes of erroneous beats are dropped; reads of erroneous beats return RDATA=0. The full beat count is still transferred.
- Write FSM:
  - W_IDLE: AWREADY=1. On AWVALID, latch AWADDR/AWLEN/AWBURST/AWID and go to W_DATA. AWREADY drops the next cycle.
  - W_DATA: WREADY=1. Each WVALID&WREADY writes the strobed bytes and advances the beat counter. After beat AWLEN+1 go to W_RESP. There is no WLAST; beat count comes from AWLEN only.
  - W_RESP: BVALID=1, BID=latched AWID, BRESP=accumulated status. On BREADY go to W_IDLE.
- Read FSM:
  - R_IDLE: ARREADY=1. On ARVALID, latch the request and go to R_LOAD.
  - R_LOAD: registered memory read, 1 cycle. Then go to R_DATA.
  - R_DATA: RVALID=1 and RDATA/RRESP/RID stable until RREADY.
    - On RREADY with beats remaining: go back to R_LOAD. Minimum 2 cycles per beat.
    - On the final beat: go to R_IDLE.
  - First RVALID appears 2 cycles after the AR handshake.
- Read and write to the same word in the same cycle: the read register captures the pre-write value.
- Doorbell: the word at index depth-1 is also mirrored into the IRQ register. On a write beat to that index, IRQ <= (IRQ & ~byte_mask) | (WDATA & byte_mask), taken over the low irq_width bits. IRQ updates the edge after the beat.
- Handshake rules: AWREADY, ARREADY, WREADY and BVALID/RVALID never depend combinationally on inputs. Once asserted, BVALID and RVALID hold until accepted.
- Reset mid-burst: the transaction is abandoned. No B or R response is issued and the doorbell is cleared.

Optional Feature:
- Macro: AXI4_SLAVE_MEM_STALL_EN.
- Defined:
  - An 8-bit Fibonacci LFSR (taps 8,6,5,4) is seeded to 8'hA5 on reset and steps every cycle.
  - While lfsr[0]=1: WREADY is forced 0, and R_LOAD does not advance to R_DATA.
  - The LFSR never retracts a VALID signal that is already asserted.
- Undefined: there is no LFSR, and timing is exactly as described in Behaviour.

Test Plan:
- INCR write, AWADDR=0x100, AWLEN=3, data 0x11..0x44, then INCR read of the same 4 beats -> BRESP=00, BID=AWID; RDATA 0x11,0x22,0x33,0x44 with RRESP=00.
- WRAP read, ARADDR=0x10C, ARLEN=3, after filling words 0x40-0x43 with their index -> index order 0x43,0x40,0x41,0x42.
- Write WSTRB=4'b0010, WDATA=0xFFFFFFFF to a word holding 0x12345678 -> read returns 0x1234FF78.
- ARADDR=0x1000 with mem_aw=10, 32-bit data, ARLEN=1 -> 2 beats of RDATA=0 with RRESP=10. AWBURST=11 -> BRESP=10 and memory unchanged.
- Write 0x1 to byte address 0xFFC -> IRQ rises 1 cycle after the W beat. Then write 0x0 -> IRQ falls.
- Assert ARESETn=0 during beat 2 of a 4-beat write, then release -> all outputs 0, no BVALID, and AWREADY=1 the first cycle after release.
